// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the register-file write arbiter and its requesters.
//   req       : per-requester write request (level, held until acked)
//   req_addr  : packed requester addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data  : packed requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   hold      : pipeline freeze, suppresses granting for the cycle
//   ack       : one-hot, one-cycle issue pulse back to the requester
//   rf_we/rf_waddr/rf_wdata : registered register-file write port
//   busy      : registered "requests left waiting last cycle" flag
// slave  : arbiter side; master : requester / register-file side.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          hold;
  logic [NUM_REQ-1:0]            ack;
  logic                          rf_we;
  logic [ADDR_WIDTH-1:0]         rf_waddr;
  logic [DATA_WIDTH-1:0]         rf_wdata;
  logic                          busy;

  modport slave (
    input  req, req_addr, req_data, hold,
    output ack, rf_we, rf_waddr, rf_wdata, busy
  );

  modport master (
    output req, req_addr, req_data, hold,
    input  ack, rf_we, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among
// NUM_REQ requesters. One grant per cycle; the winner's address/data are
// registered onto the write port together with a one-cycle ack. Writes to
// register 0 are acked but rf_we stays low ($zero is hardwired).
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous, active-high
//   bus   : regfile_write_arbiter_if.slave (requests, hold, ack, write port, busy)
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  regfile_write_arbiter_if.slave    bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    ack_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  busy_q;
  logic [PTR_W-1:0]      ptr_q;

  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    win_oh;
  logic                  found;
  logic [PTR_W-1:0]      win_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [PTR_W-1:0]      ptr_d;
  logic                  busy_d;
  int unsigned           scan;

  // Priority scan starting at ptr_q and wrapping modulo NUM_REQ, so a
  // non-power-of-2 requester count never yields an invalid index.
  always_comb begin
    elig     = bus.req & ~ack_q;   // just-acked requesters cannot win again yet
    found    = 1'b0;
    win_idx  = '0;
    win_oh   = '0;
    scan     = 0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = 32'(ptr_q) + k;
      if (scan >= NUM_REQ) begin
        scan = scan - NUM_REQ;
      end
      if (!bus.hold && !found && (|(elig & (NUM_REQ'(1) << scan)))) begin
        found   = 1'b1;
        win_idx = PTR_W'(scan);
      end
    end
    if (found) begin
      win_oh = NUM_REQ'(1) << win_idx;
    end
    // One-hot AND-OR mux for the winner's address/data.
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (win_oh[j]) begin
        sel_addr = sel_addr | bus.req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = sel_data | bus.req_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
    busy_d = |(elig & ~win_oh);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      ack_q  <= win_oh;
      we_q   <= found && (sel_addr != '0);
      busy_q <= busy_d;
      ptr_q  <= ptr_d;
      if (found) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.rf_we    = we_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a 4-requester instance
// checked cycle by cycle against a scoreboard fed by a reference model,
// plus directed constant checks, and a 3-requester instance for pointer wrap.
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
  regfile_write_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(32), .ADDR_WIDTH(5)) bus3 ();

  regfile_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  regfile_write_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  typedef struct {
    logic [3:0]  ack;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
  } exp_t;

  exp_t sbq[$];

  int n_checks = 0;
  int n_errors = 0;

  // requester state driven onto the bus
  logic [4:0]  a[4];
  logic [31:0] d[4];
  logic [3:0]  pend   = '0;
  logic [3:0]  sticky = '0;

  // reference model state
  int          m_ptr   = 0;
  logic [3:0]  m_ack   = '0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;

  logic [3:0] ack_o;
  logic       busy_o;
  logic [2:0] wrap_exp[4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, model the outcome, push expectation,
  // then pop and compare just after the posedge.
  task automatic step(input string tag, input logic rst_v, input logic h,
                      output logic [3:0] ack_obs, output logic busy_obs);
    exp_t       e;
    exp_t       g;
    logic [3:0] ack_in;
    logic [3:0] elig;
    logic [3:0] oh;
    logic [7:0] dbl;
    int         pos;
    int         w;
    @(negedge clk);
    reset    = rst_v;
    bus.hold = h;
    bus.req  = pend;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i*5 +: 5]   = a[i];
      bus.req_data[i*32 +: 32] = d[i];
    end
    ack_in = m_ack;
    oh     = '0;
    e.we   = 1'b0;
    e.busy = 1'b0;
    if (rst_v) begin
      m_ptr   = 0;
      m_ack   = '0;
      m_waddr = '0;
      m_wdata = '0;
    end else begin
      elig = pend & ~m_ack;
      if (!h && elig != 4'b0) begin
        dbl = {elig, elig} >> m_ptr;
        pos = 0;
        while (!dbl[pos]) pos++;
        w = (m_ptr + pos) % 4;
        oh[w]   = 1'b1;
        m_waddr = a[w];
        m_wdata = d[w];
        e.we    = (a[w] != 5'd0);
        m_ptr   = (w + 1) % 4;
      end
      e.busy = |(elig & ~oh);
      m_ack  = oh;
    end
    e.ack   = m_ack;
    e.waddr = m_waddr;
    e.wdata = m_wdata;
    sbq.push_back(e);
    // requesters that saw ack this cycle drop (or re-present) at the edge
    pend = (pend & ~ack_in) | sticky;
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    check({tag, ".ack"},   64'(bus.ack),      64'(g.ack));
    check({tag, ".we"},    64'(bus.rf_we),    64'(g.we));
    check({tag, ".waddr"}, 64'(bus.rf_waddr), 64'(g.waddr));
    check({tag, ".wdata"}, 64'(bus.rf_wdata), 64'(g.wdata));
    check({tag, ".busy"},  64'(bus.busy),     64'(g.busy));
    ack_obs  = bus.ack;
    busy_obs = bus.busy;
  endtask

  initial begin
    bus.req = '0; bus.hold = 1'b0; bus.req_addr = '0; bus.req_data = '0;
    bus3.req = '0; bus3.hold = 1'b0;
    bus3.req_addr = {5'd7, 5'd6, 5'd5};
    bus3.req_data = {32'h33, 32'h22, 32'h11};
    for (int i = 0; i < 4; i++) begin
      a[i] = 5'(i + 1);
      d[i] = $urandom;
    end
    wrap_exp[0] = 3'b001; wrap_exp[1] = 3'b010; wrap_exp[2] = 3'b100; wrap_exp[3] = 3'b001;

    // reset with all requests asserted
    pend = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      step("rst", 1'b1, 1'b0, ack_o, busy_o);
      check("rst.ack0", 64'(ack_o), 64'd0);
      check("rst.we0", 64'(bus.rf_we), 64'd0);
      check("rst.waddr0", 64'(bus.rf_waddr), 64'd0);
      check("rst.wdata0", 64'(bus.rf_wdata), 64'd0);
    end

    // all four request, each drops after its ack
    step("rr1", 1'b0, 1'b0, ack_o, busy_o);
    check("rr1.order", 64'(ack_o), 64'b0001); check("rr1.bz", 64'(busy_o), 64'd1);
    step("rr2", 1'b0, 1'b0, ack_o, busy_o);
    check("rr2.order", 64'(ack_o), 64'b0010); check("rr2.bz", 64'(busy_o), 64'd1);
    step("rr3", 1'b0, 1'b0, ack_o, busy_o);
    check("rr3.order", 64'(ack_o), 64'b0100); check("rr3.bz", 64'(busy_o), 64'd1);
    step("rr4", 1'b0, 1'b0, ack_o, busy_o);
    check("rr4.order", 64'(ack_o), 64'b1000); check("rr4.bz", 64'(busy_o), 64'd0);
    step("rr5", 1'b0, 1'b0, ack_o, busy_o);
    check("rr5.noack", 64'(ack_o), 64'd0);

    // single requester 2
    a[2] = 5'd9; d[2] = 32'hDEADBEEF; pend = 4'b0100;
    step("s2a", 1'b0, 1'b0, ack_o, busy_o);
    check("s2.ack", 64'(ack_o), 64'b0100);
    check("s2.we", 64'(bus.rf_we), 64'd1);
    check("s2.waddr", 64'(bus.rf_waddr), 64'd9);
    check("s2.wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
    step("s2b", 1'b0, 1'b0, ack_o, busy_o);
    check("s2.nodup_we", 64'(bus.rf_we), 64'd0);
    check("s2.nodup_ack", 64'(ack_o), 64'd0);
    step("s2c", 1'b0, 1'b0, ack_o, busy_o);

    // write to $zero: acked, no write strobe
    a[1] = 5'd0; d[1] = 32'h12345678; pend = 4'b0010;
    step("z0a", 1'b0, 1'b0, ack_o, busy_o);
    check("z0.ack", 64'(ack_o), 64'b0010);
    check("z0.we", 64'(bus.rf_we), 64'd0);
    step("z0b", 1'b0, 1'b0, ack_o, busy_o);

    // hold for 3 cycles with requesters 0 and 2 pending, ptr at 2
    a[0] = 5'd17; pend = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b0, 1'b1, ack_o, busy_o);
      check("hold.noack", 64'(ack_o), 64'd0);
      check("hold.nowe", 64'(bus.rf_we), 64'd0);
    end
    step("hr1", 1'b0, 1'b0, ack_o, busy_o);
    check("hold.first", 64'(ack_o), 64'b0100);
    step("hr2", 1'b0, 1'b0, ack_o, busy_o);
    check("hold.second", 64'(ack_o), 64'b0001);
    step("hr3", 1'b0, 1'b0, ack_o, busy_o);

    // requester 3 continuous, requester 1 once
    sticky = 4'b1000; pend = 4'b1000;
    step("c1", 1'b0, 1'b0, ack_o, busy_o);
    check("cont.r3", 64'(ack_o), 64'b1000);
    pend = pend | 4'b0010;
    step("c2", 1'b0, 1'b0, ack_o, busy_o);
    check("cont.r1", 64'(ack_o), 64'b0010);
    step("c3", 1'b0, 1'b0, ack_o, busy_o);
    check("cont.r3b", 64'(ack_o), 64'b1000);
    step("c4", 1'b0, 1'b0, ack_o, busy_o);
    sticky = '0;
    for (int i = 0; i < 3; i++) step("cdrain", 1'b0, 1'b0, ack_o, busy_o);

    // reset while a grant is in flight
    pend = 4'b0110;
    step("mr0", 1'b0, 1'b0, ack_o, busy_o);
    step("mr1", 1'b1, 1'b0, ack_o, busy_o);
    check("mrst.ack", 64'(ack_o), 64'd0);
    check("mrst.we", 64'(bus.rf_we), 64'd0);
    check("mrst.waddr", 64'(bus.rf_waddr), 64'd0);
    pend = 4'b1111;
    step("mr2", 1'b0, 1'b0, ack_o, busy_o);
    check("mrst.first", 64'(ack_o), 64'b0001);
    for (int i = 0; i < 5; i++) step("mrdrain", 1'b0, 1'b0, ack_o, busy_o);

    // 3-requester build: pointer wraps 2 -> 0
    @(negedge clk);
    bus3.req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("wrap3.ack%0d", i), 64'(bus3.ack), 64'(wrap_exp[i]));
      check($sformatf("wrap3.we%0d", i), 64'(bus3.rf_we), 64'd1);
    end
    @(negedge clk);
    bus3.req = '0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of the CPU register file between up to NUM_REQ requesters, such as the ALU writeback, the load unit and the HI/LO or link path. The outputs of each requester come from plain clocked registers. Each requester presents an address and data and holds a request until it receives a one-cycle ack. The arbiter drives a registered write strobe, address and data into the register-file write port. Writes to register 0 are acked but suppressed, because MIPS $zero is hardwired.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
DATA_WIDTH, 32, write data width.
ADDR_WIDTH, 5, register address width (32 registers).

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  reset, synchronous, active-high.
req  input  NUM_REQ  per-requester write request; level, held until acked.
req_addr  input  NUM_REQ*ADDR_WIDTH  requester i address in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
req_data  input  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
hold  input  1  pipeline freeze; when 1, no grant is issued this cycle.
ack  output  NUM_REQ  one-hot, one-cycle pulse: requester i's write has been issued.
rf_we  output  1  register-file write enable.
rf_waddr  output  ADDR_WIDTH  register-file write address.
rf_wdata  output  DATA_WIDTH  register-file write data.
busy  output  1  registered; 1 when any req bit was pending and unserved last cycle.

Behaviour:
- Reset (sampled at posedge with reset=1):
  - ack=0, rf_we=0, rf_waddr=0, rf_wdata=0, busy=0.
  - Round-robin pointer ptr=0.
  - Reset overrides every other input, including req in the same cycle.
- Eligible set in cycle t: elig = req & ~ack. The ack mask stops a requester from being granted twice before it can deassert.
- Arbitration, combinational in cycle t:
  - If hold=0 and elig!=0, the winner w is the first set bit of elig scanning ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
- Registered outcome at the posedge ending cycle t, when a winner exists:
  - ack = one-hot(w).
  - rf_waddr = req_addr[w], rf_wdata = req_data[w].
  - rf_we = 1 if req_addr[w]!=0, else 0. The ack is still issued when the address is 0.
  - ptr = (w+1) mod NUM_REQ.
- Registered outcome when there is no winner (hold=1 or elig=0):
  - ack=0, rf_we=0, ptr unchanged.
  - rf_waddr and rf_wdata hold their previous values.
- Latency:
  - Request to rf_we/ack is 1 cycle when uncontended.
  - Worst-case wait is (NUM_REQ-1) grants plus hold cycles; there is no starvation.
- Requester contract:
  - Address and data stay stable while req=1.
  - On seeing ack=1 in cycle t+1, the requester deasserts req or presents a new write at the posedge ending t+1. The arbiter cannot grant it in t+1 because of the mask.
- Throughput: one write per cycle whenever hold=0 and at least one other requester is eligible.
- busy = |(elig & ~one-hot(w)) computed in cycle t, registered.
- Simultaneous events:
  - hold=1 with requests pending: no grant and ptr frozen; grants resume in order when hold drops.
  - A requester deasserting req in the same cycle it would win loses that cycle; no ack is issued to it.
- Reset mid-operation: any in-flight ack or rf_we is cleared on the next posedge and pending requests are not remembered. Requesters re-request after reset deasserts.
- Non-power-of-2 NUM_REQ: ptr wraps to 0 after NUM_REQ-1, never to an invalid index.

Test Plan:
1. Reset held 2 cycles with req=4'b1111 -> ack=0, rf_we=0, rf_waddr=0, rf_wdata=0, busy=0 throughout; first grant after release goes to requester 0.
2. Single requester 2, addr=5'd9, data=32'hDEADBEEF, req held until ack:
   - rf_we=1, rf_waddr=9, rf_wdata=DEADBEEF and ack=4'b0100 exactly one cycle after the request.
   - Exactly one write, no duplicate.
3. req=4'b1111 held, each requester deasserting on ack:
   - Acks in order 0001, 0010, 0100, 1000 on consecutive cycles.
   - busy=1 for the first three cycles.
4. Requester 1 writes addr=0, data=32'h12345678 -> ack=4'b0010 pulses, rf_we stays 0.
5. hold=1 for 3 cycles with req=4'b0101 and ptr=2:
   - No ack and no rf_we during hold.
   - After hold drops: requester 2 acked first, then requester 0.
6. Requester 3 requests continuously, re-requesting immediately after each ack, while requester 1 requests once -> requester 1 acked within 2 cycles (alternation 3, 1); NUM_REQ=3 build wraps ptr 2->0.
